// File: rtl/check_stream_arbiter.sv
// check_stream_arbiter: locks a shared checker input to one of two
// character streams per record. Optional length limit: CHK_ARB_TIMEOUT_EN.
module check_stream_arbiter #(
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_char,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_char,
  output logic        req1_ready,
  output logic [7:0]  out_char,
  output logic        out_valid,
  output logic [1:0]  grant,
  output logic [15:0] rec_count,
  output logic        abort
);

  localparam logic [7:0] CARET = 8'h5E;
  localparam logic [7:0] STAR  = 8'h2A;
  localparam logic [7:0] HASH  = 8'h23;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       favor;
  logic       favor_nx;
  logic       st0;
  logic       st1;
  logic       tie;
  logic       lk_valid;
  logic [7:0] lk_char;
  logic       fwd;
  logic [7:0] fwd_char;
  logic       done;
  logic       at_max;

  assign st0 = req0_valid &&
               (req0_char == CARET || req0_char == STAR);
  assign st1 = req1_valid &&
               (req1_char == CARET || req1_char == STAR);
  assign tie = st0 && st1;

  assign lk_valid = (state == LOCK0) ? req0_valid : req1_valid;
  assign lk_char  = (state == LOCK0) ? req0_char  : req1_char;

  assign grant = {state == LOCK1, state == LOCK0};

`ifdef CHK_ARB_TIMEOUT_EN
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [LW-1:0] len;
  logic          kill;
  logic          abort_q;

  assign at_max = (len == LW'(MAX_LEN - 1));
  assign kill   = (state != IDLE) && lk_valid &&
                  (lk_char != HASH) && at_max;
  assign abort  = abort_q;

  // Characters accepted in the current lock, start char counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len     <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= kill;
      if (fwd && state == IDLE)
        len <= LW'(1);
      else if (done || kill)
        len <= '0;
      else if (fwd)
        len <= len + LW'(1);
    end
  end
`else
  assign at_max = 1'b0;
  assign abort  = 1'b0;
`endif

  // State register and tie-break pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      favor <= 1'b0;
    end else begin
      state <= state_nx;
      favor <= favor_nx;
    end
  end

  // Arbitration, handshake and next-state decode.
  always_comb begin
    state_nx   = state;
    favor_nx   = favor;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fwd        = 1'b0;
    fwd_char   = 8'h00;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = !(tie && favor);
        req1_ready = !(tie && !favor);
        if (st0 && !(tie && favor)) begin
          fwd      = 1'b1;
          fwd_char = req0_char;
          state_nx = LOCK0;
          favor_nx = 1'b1;
        end else if (st1) begin
          fwd      = 1'b1;
          fwd_char = req1_char;
          state_nx = LOCK1;
          favor_nx = 1'b0;
        end
      end
      LOCK0, LOCK1: begin
        req0_ready = (state == LOCK0);
        req1_ready = (state == LOCK1);
        if (lk_valid) begin
          fwd      = 1'b1;
          fwd_char = lk_char;
          if (lk_char == HASH) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else if (at_max) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered forward path and saturating record counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      rec_count <= 16'h0000;
    end else begin
      out_valid <= fwd;
      out_char  <= fwd_char;
      if (done && rec_count != 16'hFFFF)
        rec_count <= rec_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_check_stream_arbiter.sv
// tb_check_stream_arbiter: directed vectors plus sequences for
// record streaming, reset abort, length limit and counter saturation.
module tb_check_stream_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [7:0]  req0_char;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_char;
  logic        req1_ready;
  logic [7:0]  out_char;
  logic        out_valid;
  logic [1:0]  grant;
  logic [15:0] rec_count;
  logic        abort;

  int n_pass = 0;
  int n_tot  = 0;

  check_stream_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_char  (req0_char),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_char  (req1_char),
    .req1_ready (req1_ready),
    .out_char   (out_char),
    .out_valid  (out_valid),
    .grant      (grant),
    .rec_count  (rec_count),
    .abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [7:0]  c0;
    logic        v1;
    logic [7:0]  c1;
    logic        r0;
    logic        r1;
    logic        ov;
    logic [7:0]  oc;
    logic [1:0]  g;
    logic [15:0] rc;
  } vec_t;

  vec_t tbl[15];

  function automatic void chk(input string name,
                              input logic [15:0] act,
                              input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic drive(input logic v0, input logic [7:0] c0,
                       input logic v1, input logic [7:0] c1);
    req0_valid = v0;
    req0_char  = c0;
    req1_valid = v1;
    req1_char  = c1;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string s;
    logic [7:0] c;

    tbl[0]  = '{1, 8'h61, 0, 8'h00, 1, 1, 0, 8'h00, 2'b00, 16'd0};
    tbl[1]  = '{1, 8'h5E, 1, 8'h5E, 1, 0, 1, 8'h5E, 2'b01, 16'd0};
    tbl[2]  = '{1, 8'h78, 1, 8'h2A, 1, 0, 1, 8'h78, 2'b01, 16'd0};
    tbl[3]  = '{1, 8'h23, 1, 8'h2A, 1, 0, 1, 8'h23, 2'b00, 16'd1};
    tbl[4]  = '{1, 8'h2A, 1, 8'h2A, 0, 1, 1, 8'h2A, 2'b10, 16'd1};
    tbl[5]  = '{1, 8'h5E, 1, 8'h5E, 0, 1, 1, 8'h5E, 2'b10, 16'd1};
    tbl[6]  = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h00, 2'b10, 16'd1};
    tbl[7]  = '{0, 8'h00, 1, 8'h23, 0, 1, 1, 8'h23, 2'b00, 16'd2};
    tbl[8]  = '{0, 8'h00, 1, 8'h61, 1, 1, 0, 8'h00, 2'b00, 16'd2};
    tbl[9]  = '{0, 8'h00, 1, 8'h62, 1, 1, 0, 8'h00, 2'b00, 16'd2};
    tbl[10] = '{0, 8'h00, 1, 8'h23, 1, 1, 0, 8'h00, 2'b00, 16'd2};
    tbl[11] = '{1, 8'h71, 1, 8'h5E, 1, 1, 1, 8'h5E, 2'b10, 16'd2};
    tbl[12] = '{0, 8'h00, 1, 8'h23, 0, 1, 1, 8'h23, 2'b00, 16'd3};
    tbl[13] = '{1, 8'h5E, 1, 8'h5E, 1, 0, 1, 8'h5E, 2'b01, 16'd3};
    tbl[14] = '{1, 8'h23, 0, 8'h00, 1, 0, 1, 8'h23, 2'b00, 16'd4};

    reset = 1'b0;
    req0_valid = 1'b0;
    req0_char  = 8'h00;
    req1_valid = 1'b0;
    req1_char  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 16'(out_valid), 16'd0);
    chk("rst_oc", 16'(out_char), 16'h00);
    chk("rst_grant", 16'(grant), 16'd0);
    chk("rst_rc", rec_count, 16'd0);
    chk("rst_abort", 16'(abort), 16'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1);
      chk($sformatf("v%0d_r0", i), 16'(req0_ready), 16'(tbl[i].r0));
      chk($sformatf("v%0d_r1", i), 16'(req1_ready), 16'(tbl[i].r1));
      tick();
      chk($sformatf("v%0d_ov", i), 16'(out_valid), 16'(tbl[i].ov));
      chk($sformatf("v%0d_oc", i), 16'(out_char), 16'(tbl[i].oc));
      chk($sformatf("v%0d_g", i), 16'(grant), 16'(tbl[i].g));
      chk($sformatf("v%0d_rc", i), rec_count, tbl[i].rc);
      chk($sformatf("v%0d_ab", i), 16'(abort), 16'd0);
    end

    s = "^242@000030f4: $31 <= 12345678#";
    for (int i = 0; i < s.len(); i++) begin
      drive(1'b1, s[i], 1'b0, 8'h00);
      chk($sformatf("str%0d_r0", i), 16'(req0_ready), 16'd1);
      tick();
      chk($sformatf("str%0d_ov", i), 16'(out_valid), 16'd1);
      chk($sformatf("str%0d_oc", i), 16'(out_char), 16'(s[i]));
      chk($sformatf("str%0d_g", i), 16'(grant),
          (i == s.len() - 1) ? 16'd0 : 16'd1);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("str_rc", rec_count, 16'd5);
    tick();
    chk("str_idle_ov", 16'(out_valid), 16'd0);
    chk("str_idle_oc", 16'(out_char), 16'h00);

    s = "*00000088 <=";
    for (int i = 0; i < s.len(); i++) begin
      drive(1'b1, s[i], 1'b0, 8'h00);
      tick();
      chk($sformatf("pre%0d_oc", i), 16'(out_char), 16'(s[i]));
    end
    chk("pre_g", 16'(grant), 16'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", 16'(out_valid), 16'd0);
    chk("mid_rst_g", 16'(grant), 16'd0);
    chk("mid_rst_rc", rec_count, 16'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    #10;
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 8'h2A);
    chk("post_r1", 16'(req1_ready), 16'd1);
    tick();
    chk("post_g", 16'(grant), 16'd2);
    chk("post_oc", 16'(out_char), 16'h2A);
    drive(1'b0, 8'h00, 1'b1, 8'h23);
    tick();
    chk("post_rc", rec_count, 16'd1);
    chk("post_g_idle", 16'(grant), 16'd0);

    for (int i = 0; i < 71; i++) begin
      c = (i == 0) ? 8'h5E : 8'h31;
      drive(1'b1, c, 1'b0, 8'h00);
      chk($sformatf("len%0d_r0", i), 16'(req0_ready), 16'd1);
      tick();
`ifdef CHK_ARB_TIMEOUT_EN
      chk($sformatf("len%0d_ov", i), 16'(out_valid),
          (i <= 63) ? 16'd1 : 16'd0);
      chk($sformatf("len%0d_oc", i), 16'(out_char),
          (i <= 63) ? 16'(c) : 16'h00);
      chk($sformatf("len%0d_g", i), 16'(grant),
          (i < 63) ? 16'd1 : 16'd0);
      chk($sformatf("len%0d_ab", i), 16'(abort),
          (i == 63) ? 16'd1 : 16'd0);
`else
      chk($sformatf("len%0d_ov", i), 16'(out_valid), 16'd1);
      chk($sformatf("len%0d_oc", i), 16'(out_char), 16'(c));
      chk($sformatf("len%0d_g", i), 16'(grant), 16'd1);
      chk($sformatf("len%0d_ab", i), 16'(abort), 16'd0);
`endif
    end
`ifdef CHK_ARB_TIMEOUT_EN
    chk("len_rc", rec_count, 16'd1);
`else
    drive(1'b1, 8'h23, 1'b0, 8'h00);
    tick();
    chk("len_end_g", 16'(grant), 16'd0);
    chk("len_rc", rec_count, 16'd2);
`endif
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    chk("len_after_ab", 16'(abort), 16'd0);

    force dut.rec_count = 16'hFFFE;
    #1;
    release dut.rec_count;
    #1;
    chk("sat_base", rec_count, 16'hFFFE);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'h5E, 1'b0, 8'h00);
      tick();
      drive(1'b1, 8'h23, 1'b0, 8'h00);
      tick();
      chk($sformatf("sat%0d_rc", k), rec_count, 16'hFFFF);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
